// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states and the parity-mode encoding used by uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    WAIT  = 2'd3
  } arb_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_tx data handshake, bundled for the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;

  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          tx_done;

  // Driven by the requesters and the uart_tx model.
  modport master (
    output req_data,
    output req_valid,
    output req_last,
    input  req_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done
  );

  // Used by the arbiter.
  modport slave (
    input  req_data,
    input  req_valid,
    input  req_last,
    output req_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational rotate-priority search: first set request at or above rr_ptr, wrapping to 0.
module uart_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_req
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [IdW-1:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IdW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locking arbiter sharing one uart_tx among NUM_REQ byte streams.
// Optional stall timeout on a locked requester: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_arbiter_if.slave           bus,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                       timeout_evt
`endif
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

  localparam logic [IdW-1:0]  LastId    = IdW'(NUM_REQ - 1);
  localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..256");
  end
  if (IDLE_TIMEOUT < 1) begin : g_bad_idle_timeout
    $error("IDLE_TIMEOUT must be nonzero");
  end

  arb_state_t            state_q, state_d;
  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]        grant_id_q, grant_id_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  last_q, last_d;
  logic                  frame_done_q, frame_done_d;

  logic [IdW-1:0]        winner;
  logic                  any_req;
  logic                  release_lock;
  logic [NUM_REQ-1:0]    req_ready;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
  logic                  gnt_valid;
  logic                  gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign gnt_valid = bus.req_valid[grant_id_q];
  assign gnt_last  = bus.req_last[grant_id_q];
  assign gnt_data  = req_bytes[grant_id_q];

  uart_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .any_req(any_req)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned        StallW    = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [StallW-1:0]  StallLast = StallW'(IDLE_TIMEOUT - 1);

  logic [StallW-1:0] stall_q, stall_d;
  logic              timeout_q, timeout_d;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    burst_cnt_d   = burst_cnt_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    frame_done_d  = 1'b0;
    release_lock  = 1'b0;
    req_ready     = '0;
`ifdef UART_ARB_TIMEOUT_EN
    stall_d       = stall_q;
    timeout_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_id_d    = winner;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
          state_d       = FETCH;
        end
      end
      FETCH: begin
        req_ready[grant_id_q] = gnt_valid;
        if (gnt_valid) begin
          tx_data_d = gnt_data;
          last_d    = gnt_last;
          state_d   = SEND;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (stall_q == StallLast) begin
          release_lock = 1'b1;
          timeout_d    = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
`endif
        end
      end
      SEND: begin
        if (bus.tx_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (last_q || burst_cnt_q == BurstLast) release_lock = 1'b1;
          else                                    state_d      = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Releasing requester drops to lowest priority for the next arbitration.
    if (release_lock) begin
      state_d       = IDLE;
      grant_valid_d = 1'b0;
      frame_done_d  = 1'b1;
      rr_ptr_d      = (grant_id_q == LastId) ? '0 : grant_id_q + 1'b1;
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Held at zero outside FETCH so every entry into FETCH starts a fresh stall count.
    if (state_q != FETCH) stall_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      tx_data_q     <= '0;
      last_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      frame_done_q  <= frame_done_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_evt = timeout_q;
`endif

  assign bus.req_ready = req_ready;
  assign bus.tx_valid  = (state_q == SEND);
  assign bus.tx_data   = tx_data_q;
  assign grant_valid   = grant_valid_q;
  assign grant_id      = grant_id_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester FIFOs, a uart_tx model and a decoupled monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned NR    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned MB    = 4;
  localparam int unsigned IT    = 100;
  localparam int          FRAME = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       frame_done;
`ifdef UART_ARB_TIMEOUT_EN
  logic       timeout_evt;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .DATA_WIDTH  (DW),
    .MAX_BURST   (MB),
    .IDLE_TIMEOUT(IT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .frame_done (frame_done)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_evt(timeout_evt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] exp_q  [$];  // {grant_id, byte} in expected uart order
  logic [1:0] exp_fd [$];  // releasing grant_id per frame_done pulse

  logic [8:0]    rmem  [NR][64];  // {last, byte}
  int            rhead [NR];
  int            rtail [NR];
  logic [NR-1:0] hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
  endtask

  task automatic queue_byte(input int id, input logic [7:0] d, input logic last);
    rmem[id][rtail[id]] = {last, d};
    rtail[id]++;
  endtask

  task automatic expect_byte(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_fd.size() != 0 || grant_valid) && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    check(name, 32'(exp_q.size() + exp_fd.size()), 32'd0);
    exp_q.delete();
    exp_fd.delete();
  endtask

  // Requesters: present FIFO heads at negedge, pop what was accepted on the last posedge.
  initial begin
    logic [NR-1:0] acc;
    acc           = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && rhead[i] < rtail[i]) rhead[i]++;
        if (rhead[i] < rtail[i] && !hold[i]) begin
          bus.req_valid[i]           = 1'b1;
          bus.req_last[i]            = rmem[i][rhead[i]][8];
          bus.req_data[i*DW +: DW]   = rmem[i][rhead[i]][7:0];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end
      end
      #1 acc = bus.req_ready & bus.req_valid;
    end
  end

  // uart_tx model: busy for FRAME cycles after each handshake, then a tx_done pulse.
  initial begin
    int   busy;
    logic pend;
    busy         = 0;
    pend         = 1'b0;
    bus.tx_ready = 1'b1;
    bus.tx_done  = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (!rst_n) begin
        busy         = 0;
        pend         = 1'b0;
        bus.tx_ready = 1'b1;
      end else begin
        if (pend) begin
          pend         = 1'b0;
          bus.tx_ready = 1'b0;
          busy         = FRAME;
        end else if (busy > 0) begin
          busy--;
          if (busy == 0) begin
            bus.tx_done  = 1'b1;
            bus.tx_ready = 1'b1;
          end
        end
        if (bus.tx_valid && bus.tx_ready) pend = 1'b1;
      end
    end
  end

  // Monitor: compare every uart handshake and every frame_done against the scoreboard.
  initial begin
    logic [9:0] e;
    logic [1:0] f;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_byte: got id %0d byte 0x%0h, expected no byte", grant_id, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'({grant_id, bus.tx_data}), 32'(e));
        end
      end
      if (rst_n && frame_done) begin
        if (exp_fd.size() == 0) begin
          n_checks++;
          $display("FAIL frame_done: got release of id %0d, expected none", grant_id);
        end else begin
          f = exp_fd.pop_front();
          check("frame_done_id", 32'(grant_id), 32'(f));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    logic seen;
    hold = '0;
    for (int i = 0; i < NR; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    check("rst_timeout_evt", 32'(timeout_evt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, three bytes; also grant and fetch latency
    @(negedge clk);
    #4;
    expect_byte(2'd0, 8'hA5);
    expect_byte(2'd0, 8'h3C);
    expect_byte(2'd0, 8'hFF);
    exp_fd.push_back(2'd0);
    queue_byte(0, 8'hA5, 1'b0);
    queue_byte(0, 8'h3C, 1'b0);
    queue_byte(0, 8'hFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #3;
    check("t1_grant_valid", 32'(grant_valid), 32'd1);
    check("t1_grant_id", 32'(grant_id), 32'd0);
    check("t1_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    #3;
    check("t1_tx_valid", 32'(bus.tx_valid), 32'd1);
    check("t1_tx_data", 32'(bus.tx_data), 32'hA5);
    wait_drain("t1_drain", 200);

    // rr_ptr is now 1: requester 1 beats 0, then 0 wins after wrap
    @(negedge clk);
    #4;
    expect_byte(2'd1, 8'h11);
    expect_byte(2'd1, 8'h12);
    expect_byte(2'd0, 8'h01);
    expect_byte(2'd0, 8'h02);
    exp_fd.push_back(2'd1);
    exp_fd.push_back(2'd0);
    queue_byte(0, 8'h01, 1'b0);
    queue_byte(0, 8'h02, 1'b1);
    queue_byte(1, 8'h11, 1'b0);
    queue_byte(1, 8'h12, 1'b1);
    wait_drain("t2_drain", 300);

    // Stall mid-frame on requester 1
    @(negedge clk);
    #4;
    expect_byte(2'd1, 8'h21);
    expect_byte(2'd1, 8'h22);
    expect_byte(2'd1, 8'h23);
    exp_fd.push_back(2'd1);
`ifdef UART_ARB_TIMEOUT_EN
    exp_fd.push_back(2'd1);
`endif
    base = rtail[1];
    queue_byte(1, 8'h21, 1'b0);
    queue_byte(1, 8'h22, 1'b0);
    queue_byte(1, 8'h23, 1'b1);
    n = 0;
    while (rhead[1] <= base && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("t3_first_byte_taken", 32'(rhead[1] > base), 32'd1);
    hold[1] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (timeout_evt) seen = 1'b1;
    end
    check("t3_timeout_evt", 32'(seen), 32'd1);
    check("t3_timeout_released", 32'(grant_valid), 32'd0);
`else
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #3;
      if (i == 100 || i == 250 || i == 499) begin
        check("t3_stall_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("t3_stall_grant_valid", 32'(grant_valid), 32'd1);
        check("t3_stall_grant_id", 32'(grant_id), 32'd1);
      end
    end
`endif
    hold[1] = 1'b0;
    wait_drain("t3_drain", 300);

    // Burst limit: requester 2 streams 10 bytes, requester 0 waits with one byte
    @(negedge clk);
    #4;
    for (int k = 0; k < 4; k++) expect_byte(2'd2, 8'(8'h40 + k));
    expect_byte(2'd0, 8'h50);
    for (int k = 4; k < 10; k++) expect_byte(2'd2, 8'(8'h40 + k));
    exp_fd.push_back(2'd2);
    exp_fd.push_back(2'd0);
    exp_fd.push_back(2'd2);
    exp_fd.push_back(2'd2);
    for (int k = 0; k < 10; k++) queue_byte(2, 8'(8'h40 + k), (k == 9));
    @(negedge clk);
    @(negedge clk);
    #4;
    queue_byte(0, 8'h50, 1'b1);
    wait_drain("t4_drain", 500);

    // Reset during WAIT on requester 3
    @(negedge clk);
    #4;
    expect_byte(2'd3, 8'h60);
    queue_byte(3, 8'h60, 1'b0);
    queue_byte(3, 8'h61, 1'b0);
    queue_byte(3, 8'h62, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("t5_first_byte_sent", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) rhead[i] = rtail[i];
    #1;
    check("t5_rst_grant_valid", 32'(grant_valid), 32'd0);
    check("t5_rst_grant_id", 32'(grant_id), 32'd0);
    check("t5_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("t5_rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("t5_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("t5_rst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Post-reset contention between 1 and 3 starts from rr_ptr=0
    @(negedge clk);
    #4;
    expect_byte(2'd1, 8'h71);
    expect_byte(2'd1, 8'h72);
    expect_byte(2'd3, 8'h81);
    expect_byte(2'd3, 8'h82);
    exp_fd.push_back(2'd1);
    exp_fd.push_back(2'd3);
    queue_byte(1, 8'h71, 1'b0);
    queue_byte(1, 8'h72, 1'b1);
    queue_byte(3, 8'h81, 1'b0);
    queue_byte(3, 8'h82, 1'b1);
    wait_drain("t6_drain", 300);

    // Wrap: last grant was 3, requests on 0 and 2 (single-byte frames)
    @(negedge clk);
    #4;
    expect_byte(2'd0, 8'h90);
    expect_byte(2'd2, 8'hA0);
    exp_fd.push_back(2'd0);
    exp_fd.push_back(2'd2);
    queue_byte(0, 8'h90, 1'b1);
    queue_byte(2, 8'hA0, 1'b1);
    wait_drain("t7_drain", 300);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
- Round-robin arbitration with frame locking: a granted requester keeps the transmitter until it marks the last byte or hits the MAX_BURST byte limit.
- Sits between the requester blocks and the uart_tx data interface (tx_data/tx_valid/tx_ready/tx_done). Sequences one byte at a time, waiting for tx_done before fetching the next byte.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 8, byte width; must match uart_tx.
- MAX_BURST, 16, maximum bytes per grant before forced release; legal range 1..256.
- IDLE_TIMEOUT, 1024, cycles a locked requester may stall before its lock is revoked; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_last  in  NUM_REQ  marks the current byte as the end of the frame.
- req_ready  out  NUM_REQ  byte accepted from requester i this cycle.
- tx_data  out  DATA_WIDTH  to uart_tx.tx_data.
- tx_valid  out  1  to uart_tx.tx_valid.
- tx_ready  in  1  from uart_tx.tx_ready.
- tx_done  in  1  from uart_tx.tx_done (1-cycle pulse).
- grant_valid  out  1  a requester currently holds the lock.
- grant_id  out  $clog2(NUM_REQ)  index of the lock holder.
- frame_done  out  1  1-cycle pulse when a lock is released.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, tx_valid=0, tx_data=0.
  - grant_valid=0, grant_id=0, frame_done=0, burst_cnt=0.
- Reset mid-operation aborts the frame immediately. No byte is replayed; uart_tx shares rst_n.
- States:
  - IDLE:
    - winner = first i with req_valid[i], searching from rr_ptr upward and wrapping NUM_REQ-1 -> 0.
    - If any req_valid: grant_id<=winner, grant_valid<=1, burst_cnt<=0, go to FETCH. Otherwise stay.
  - FETCH:
    - req_ready[grant_id] = req_valid[grant_id], combinational. All other req_ready bits are 0.
    - On accept: tx_data<=req_data[grant_id], last_q<=req_last[grant_id], go to SEND.
    - If req_valid[grant_id] is low, stay in FETCH; requesters that are not granted are ignored.
  - SEND:
    - tx_valid=1 and tx_data is held stable.
    - On tx_valid&&tx_ready, go to WAIT; tx_valid deasserts in WAIT.
  - WAIT:
    - Wait for tx_done, then burst_cnt<=burst_cnt+1.
    - If last_q or burst_cnt==MAX_BURST-1: go to IDLE, grant_valid<=0, frame_done pulses 1 cycle, rr_ptr<=(grant_id==NUM_REQ-1)?0:grant_id+1.
    - Otherwise go to FETCH.
- Latency:
  - Request to grant: 1 cycle.
  - req_ready to tx_valid: 1 cycle.
  - Each byte: acceptance to next FETCH = uart frame time + 1 cycle.
- Only one req_ready bit is ever high. tx_valid is never high outside SEND.
- Simultaneous requests resolve purely by rr_ptr order. A requester that just released has the lowest priority on the next arbitration.
- tx_done outside WAIT is ignored.
- burst_cnt width is $clog2(MAX_BURST)+1; it never wraps because release occurs at MAX_BURST.
- A requester may assert req_last on the first byte (single-byte frame).

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter runs while in FETCH with req_valid[grant_id]=0 and clears on entering FETCH.
  - When it reaches IDLE_TIMEOUT-1: release the lock exactly as a frame end (frame_done pulse, rr_ptr advance), go to IDLE.
  - Adds output timeout_evt, a 1-cycle pulse on that release.
- Undefined: no counter and no timeout_evt port. A locked requester holds the transmitter indefinitely.

Decomposition:
- uart_pkg holds:
  - arb_state_t enum (IDLE, FETCH, SEND, WAIT);
  - the parity-mode constants (PARITY_NONE=0, PARITY_EVEN=1, PARITY_ODD=2), shared with uart_tx.
- Sub-module uart_rr_arbiter:
  - combinational rotate-priority search;
  - inputs: req vector, rr_ptr;
  - outputs: winner index, any_req.

Test Plan:
- Single requester: req 0 sends 3 bytes 0xA5,0x3C,0xFF (last on 0xFF) -> uart_tx sees exactly 3 tx_valid&&tx_ready handshakes in order, each after the prior tx_done; frame_done pulses once; rr_ptr=1.
- Contention: req 1 and req 3 both valid from reset, rr_ptr=0 -> grant_id=1 frame completes first, then grant_id=3, with no interleaving of bytes.
- Burst limit: MAX_BURST=4, req 2 streams 10 bytes with no last while req 0 waits -> req 2 releases after 4 bytes; req 0 granted next; req 2 resumes later.
- Stall: granted requester drops req_valid for 500 cycles mid-frame -> arbiter holds in FETCH with tx_valid=0 and grant_id unchanged. With UART_ARB_TIMEOUT_EN and IDLE_TIMEOUT=100: release at stall cycle 100 with timeout_evt=1.
- Reset mid-frame: assert rst_n=0 during WAIT -> all outputs return to reset values asynchronously; first post-reset arbitration starts from rr_ptr=0.
- Wrap: NUM_REQ=4, last grant id 3, requests on 0 and 2 -> grant_id=0.
